// File: rtl/datamover_pkg.sv
// rtl/datamover_pkg.sv - DataMover S2MM command/status field layout and FSM encoding
package datamover_pkg;

    localparam int CMD_W         = 72;
    localparam int CMD_TAG_LSB   = 64;
    localparam int CMD_TAG_W     = 4;
    localparam int CMD_SADDR_LSB = 32;
    localparam int CMD_SADDR_W   = 32;
    localparam int CMD_DRR_BIT   = 31;
    localparam int CMD_EOF_BIT   = 30;
    localparam int CMD_DSA_LSB   = 24;
    localparam int CMD_DSA_W     = 6;
    localparam int CMD_TYPE_BIT  = 23;
    localparam int CMD_BTT_W     = 23;

    localparam logic                 CMD_DRR       = 1'b0;
    localparam logic                 CMD_TYPE_INCR = 1'b1;
    localparam logic [CMD_DSA_W-1:0] CMD_DSA       = '0;

    localparam int STS_OKAY_BIT   = 7;
    localparam int STS_SLVERR_BIT = 6;
    localparam int STS_DECERR_BIT = 5;
    localparam int STS_INTERR_BIT = 4;
    localparam int STS_TAG_W      = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    function automatic logic [CMD_W-1:0] pack_cmd(
        input logic [CMD_TAG_W-1:0]   tag,
        input logic [CMD_SADDR_W-1:0] saddr,
        input logic                   eof,
        input logic [CMD_BTT_W-1:0]   btt
    );
        logic [CMD_W-1:0] w;
        w                              = '0;
        w[CMD_TAG_LSB +: CMD_TAG_W]     = tag;
        w[CMD_SADDR_LSB +: CMD_SADDR_W] = saddr;
        w[CMD_DRR_BIT]                  = CMD_DRR;
        w[CMD_EOF_BIT]                  = eof;
        w[CMD_DSA_LSB +: CMD_DSA_W]     = CMD_DSA;
        w[CMD_TYPE_BIT]                 = CMD_TYPE_INCR;
        w[0 +: CMD_BTT_W]               = btt;
        return w;
    endfunction

endpackage

// File: rtl/datamover_btt_calc.sv
// rtl/datamover_btt_calc.sv - burst length that never crosses a MAX_BURST_BYTES boundary
module datamover_btt_calc #(
    parameter int ADDR_WIDTH      = 32,
    parameter int BTT_WIDTH       = 23,
    parameter int MAX_BURST_BYTES = 4096
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           remaining,
    output logic [BTT_WIDTH-1:0]  btt,
    output logic                  eof
);

    localparam logic [31:0] BURST = 32'(MAX_BURST_BYTES);

    logic [31:0] offset;
    logic [31:0] room;
    logic [31:0] len;

    always_comb begin
        offset = 32'(addr) & (BURST - 32'd1);
        room   = BURST - offset;
        len    = (remaining < room) ? remaining : room;
        btt    = BTT_WIDTH'(len);
        eof    = (len == remaining);
    end

endmodule

// File: rtl/datamover_cmd_gen.sv
// rtl/datamover_cmd_gen.sv - splits a byte range into DataMover S2MM commands and checks status
module datamover_cmd_gen
    import datamover_pkg::*;
#(
    parameter int ADDR_WIDTH      = 32,
    parameter int BTT_WIDTH       = 23,
    parameter int MAX_BURST_BYTES = 4096,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic        clk_in1,
    input  logic        areset,
    input  logic        start,
    input  logic [31:0] base_addr,
    input  logic [31:0] total_bytes,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [71:0] cmd_tdata,
    output logic        cmd_tvalid,
    input  logic        cmd_tready,
    input  logic [7:0]  sts_tdata,
    input  logic        sts_tvalid,
    output logic        sts_tready
);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           remaining_q, remaining_d;
    logic [3:0]            tag_q, tag_d;
    logic [3:0]            exp_tag_q, exp_tag_d;
    logic [3:0]            outstanding_q, outstanding_d;
    logic                  error_q, error_d;
    logic                  done_q, done_d;
    logic                  busy_q, busy_d;
    logic                  cmd_tvalid_q, cmd_tvalid_d;
    logic                  sts_tready_q, sts_tready_d;
    logic [71:0]           cmd_tdata_q, cmd_tdata_d;

    logic                  cmd_hs;
    logic                  sts_hs;
    logic                  sts_bad;
    logic [BTT_WIDTH-1:0]  cmd_btt;
    logic [BTT_WIDTH-1:0]  nxt_btt;
    logic                  nxt_eof;

    // The word for the next state is built up front so every output leaves a flop.
    datamover_btt_calc #(
        .ADDR_WIDTH      (ADDR_WIDTH),
        .BTT_WIDTH       (BTT_WIDTH),
        .MAX_BURST_BYTES (MAX_BURST_BYTES)
    ) u_btt_calc (
        .addr      (addr_d),
        .remaining (remaining_d),
        .btt       (nxt_btt),
        .eof       (nxt_eof)
    );

    assign cmd_hs  = cmd_tvalid_q && cmd_tready;
    assign sts_hs  = sts_tvalid && sts_tready_q;
    assign cmd_btt = cmd_tdata_q[BTT_WIDTH-1:0];
    assign sts_bad = !sts_tdata[STS_OKAY_BIT] || sts_tdata[STS_SLVERR_BIT]
                  || sts_tdata[STS_DECERR_BIT] || sts_tdata[STS_INTERR_BIT]
                  || (sts_tdata[STS_TAG_W-1:0] != exp_tag_q)
                  || (outstanding_q == 4'd0);

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        remaining_d   = remaining_q;
        tag_d         = tag_q;
        exp_tag_d     = exp_tag_q;
        outstanding_d = outstanding_q;
        error_d       = error_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    error_d = 1'b0;
                    if (total_bytes != 32'd0) begin
                        addr_d        = ADDR_WIDTH'(base_addr);
                        remaining_d   = total_bytes;
                        tag_d         = 4'd0;
                        exp_tag_d     = 4'd0;
                        outstanding_d = 4'd0;
                        state_d       = ST_ISSUE;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_ISSUE, ST_DRAIN: begin
                if (cmd_hs) begin
                    addr_d      = addr_q + ADDR_WIDTH'(cmd_btt);
                    remaining_d = remaining_q - 32'(cmd_btt);
                    tag_d       = tag_q + 4'd1;
                end
                if (sts_hs) begin
                    exp_tag_d = exp_tag_q + 4'd1;
                    if (sts_bad) begin
                        error_d = 1'b1;
                    end
                end
                // An orphan status saturates the counter at zero instead of wrapping.
                if (cmd_hs && !sts_hs) begin
                    outstanding_d = outstanding_q + 4'd1;
                end else if (sts_hs && !cmd_hs && outstanding_q != 4'd0) begin
                    outstanding_d = outstanding_q - 4'd1;
                end
                if (state_q == ST_ISSUE && cmd_hs && remaining_d == 32'd0) begin
                    state_d = ST_DRAIN;
                end
                if (state_q == ST_DRAIN && outstanding_d == 4'd0) begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d       = (state_d != ST_IDLE);
        done_d       = (state_d == ST_DONE);
        sts_tready_d = (state_d == ST_ISSUE) || (state_d == ST_DRAIN);
        cmd_tvalid_d = (state_d == ST_ISSUE) && (outstanding_d < 4'(MAX_OUTSTANDING));
        cmd_tdata_d  = (state_d == ST_ISSUE)
                     ? pack_cmd(tag_d, 32'(addr_d), nxt_eof, CMD_BTT_W'(nxt_btt))
                     : '0;
    end

    always_ff @(posedge clk_in1 or posedge areset) begin
        if (areset) begin
            state_q       <= ST_IDLE;
            addr_q        <= '0;
            remaining_q   <= '0;
            tag_q         <= '0;
            exp_tag_q     <= '0;
            outstanding_q <= '0;
            error_q       <= 1'b0;
            done_q        <= 1'b0;
            busy_q        <= 1'b0;
            cmd_tvalid_q  <= 1'b0;
            sts_tready_q  <= 1'b0;
            cmd_tdata_q   <= '0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            remaining_q   <= remaining_d;
            tag_q         <= tag_d;
            exp_tag_q     <= exp_tag_d;
            outstanding_q <= outstanding_d;
            error_q       <= error_d;
            done_q        <= done_d;
            busy_q        <= busy_d;
            cmd_tvalid_q  <= cmd_tvalid_d;
            sts_tready_q  <= sts_tready_d;
            cmd_tdata_q   <= cmd_tdata_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign error      = error_q;
    assign cmd_tdata  = cmd_tdata_q;
    assign cmd_tvalid = cmd_tvalid_q;
    assign sts_tready = sts_tready_q;

endmodule

// File: tb/tb_datamover_cmd_gen.sv
// tb/tb_datamover_cmd_gen.sv - directed self-checking bench for datamover_cmd_gen
module tb_datamover_cmd_gen;

    logic        clk_in1;
    logic        areset;
    logic        start;
    logic [31:0] base_addr;
    logic [31:0] total_bytes;
    logic        busy;
    logic        done;
    logic        error;
    logic [71:0] cmd_tdata;
    logic        cmd_tvalid;
    logic        cmd_tready;
    logic [7:0]  sts_tdata;
    logic        sts_tvalid;
    logic        sts_tready;

    datamover_cmd_gen dut (
        .clk_in1     (clk_in1),
        .areset      (areset),
        .start       (start),
        .base_addr   (base_addr),
        .total_bytes (total_bytes),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .cmd_tdata   (cmd_tdata),
        .cmd_tvalid  (cmd_tvalid),
        .cmd_tready  (cmd_tready),
        .sts_tdata   (sts_tdata),
        .sts_tvalid  (sts_tvalid),
        .sts_tready  (sts_tready)
    );

    initial clk_in1 = 1'b0;
    always #5 clk_in1 = ~clk_in1;

    int          n_checks = 0;
    int          n_pass   = 0;

    logic [71:0] c_word [32];
    int          ncmd;
    int          sts_cnt;
    int          out_b;
    int          max_out;
    int          first_cmd_cyc;
    int          last_sts_cyc;
    int          done_cyc;
    int          held_ncmd;
    logic        held_valid;
    logic [3:0]  tagq [$];

    task automatic check_val(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in1);
        #1;
    endtask

    // Runs one transfer with a bench-side status responder that answers commands in order.
    task automatic do_xfer(input logic [31:0] base, input logic [31:0] bytes, input int hold,
                           input int bad_idx, input int stall, input int abort_after);
        logic        got_done;
        logic        prev_stall;
        logic [71:0] prev_data;
        ncmd = 0; sts_cnt = 0; out_b = 0; max_out = 0; first_cmd_cyc = -1;
        last_sts_cyc = -1; done_cyc = -1; held_ncmd = -1; held_valid = 1'bx;
        got_done = 1'b0; prev_stall = 1'b0; prev_data = '0;
        tagq.delete();
        base_addr = base; total_bytes = bytes; start = 1'b1;
        step();
        start = 1'b0;
        check_val("busy_after_start", busy, 1'b1);
        for (int c = 0; c < 600; c++) begin
            if (done) begin
                got_done = 1'b1;
                done_cyc = c;
                break;
            end
            if (prev_stall) check_val("cmd_tdata_stable", cmd_tdata, prev_data);
            if (hold > 0 && c == hold - 1) begin
                held_ncmd  = ncmd;
                held_valid = cmd_tvalid;
            end
            cmd_tready = !(stall != 0 && (c % 3) == 0);
            sts_tvalid = (tagq.size() > 0) && (c >= hold);
            sts_tdata  = (tagq.size() > 0)
                       ? (((sts_cnt == bad_idx) ? 8'h40 : 8'h80) | {4'h0, tagq[0]}) : 8'h00;
            prev_stall = cmd_tvalid && !cmd_tready;
            prev_data  = cmd_tdata;
            if (sts_tvalid && sts_tready) begin
                void'(tagq.pop_front());
                sts_cnt++;
                out_b--;
                last_sts_cyc = c;
            end
            if (cmd_tvalid && cmd_tready) begin
                if (ncmd < 32) c_word[ncmd] = cmd_tdata;
                if (first_cmd_cyc < 0) first_cmd_cyc = c;
                tagq.push_back(cmd_tdata[67:64]);
                ncmd++;
                out_b++;
            end
            if (out_b > max_out) max_out = out_b;
            if (abort_after > 0 && ncmd == abort_after) begin
                step();
                break;
            end
            step();
        end
        sts_tvalid = 1'b0;
        sts_tdata  = 8'h00;
        cmd_tready = 1'b1;
        if (abort_after == 0) begin
            check_val("done_seen", got_done, 1'b1);
            check_val("done_latency", 72'(done_cyc), 72'(last_sts_cyc + 1));
            check_val("busy_with_done", busy, 1'b1);
            step();
            check_val("done_one_cycle", done, 1'b0);
            check_val("idle_busy", busy, 1'b0);
            check_val("idle_sts_tready", sts_tready, 1'b0);
        end
    endtask

    task automatic check_cmd(input int i, input logic [31:0] saddr, input logic [22:0] btt,
                             input logic [3:0] tag, input logic eof);
        check_val($sformatf("saddr%0d", i), c_word[i][63:32], saddr);
        check_val($sformatf("btt%0d", i), c_word[i][22:0], btt);
        check_val($sformatf("tag%0d", i), c_word[i][67:64], tag);
        check_val($sformatf("eof%0d", i), c_word[i][30], eof);
        check_val($sformatf("fixed%0d", i),
                  {c_word[i][71:68], c_word[i][31], c_word[i][29:23]}, {4'h0, 1'b0, 6'h00, 1'b1});
    endtask

    initial begin
        areset = 1'b1; start = 1'b0; base_addr = '0; total_bytes = '0;
        cmd_tready = 1'b1; sts_tvalid = 1'b0; sts_tdata = '0;
        repeat (2) @(posedge clk_in1);
        #1;
        check_val("rst_busy", busy, 1'b0);
        check_val("rst_cmd_tvalid", cmd_tvalid, 1'b0);
        check_val("rst_cmd_tdata", cmd_tdata, 72'h0);
        check_val("rst_sts_tready", sts_tready, 1'b0);
        check_val("rst_done", done, 1'b0);
        areset = 1'b0;
        step();

        // three aligned bursts, immediate OKAY status
        do_xfer(32'h1000, 32'd10000, 0, -1, 0, 0);
        check_val("t1_ncmd", 72'(ncmd), 72'd3);
        check_val("t1_first_cmd", 72'(first_cmd_cyc), 72'd0);
        check_cmd(0, 32'h1000, 23'd4096, 4'd0, 1'b0);
        check_cmd(1, 32'h2000, 23'd4096, 4'd1, 1'b0);
        check_cmd(2, 32'h3000, 23'd1808, 4'd2, 1'b1);
        check_val("t1_error", error, 1'b0);

        // boundary split with a stalling consumer
        do_xfer(32'h0FF0, 32'd64, 0, -1, 1, 0);
        check_val("t2_ncmd", 72'(ncmd), 72'd2);
        check_cmd(0, 32'h0FF0, 23'd16, 4'd0, 1'b0);
        check_cmd(1, 32'h1000, 23'd48, 4'd1, 1'b1);

        // outstanding limit with status withheld for 12 cycles
        do_xfer(32'h0, 32'd40960, 12, -1, 0, 0);
        check_val("t3_held_ncmd", 72'(held_ncmd), 72'd4);
        check_val("t3_held_valid", held_valid, 1'b0);
        check_val("t3_ncmd", 72'(ncmd), 72'd10);
        check_val("t3_max_out", 72'(max_out), 72'd4);
        check_cmd(9, 32'h9000, 23'd4096, 4'd9, 1'b1);
        check_val("t3_error", error, 1'b0);

        // SLVERR on the second status
        do_xfer(32'h0, 32'd12288, 0, 1, 0, 0);
        check_val("t4_ncmd", 72'(ncmd), 72'd3);
        check_val("t4_error", error, 1'b1);

        // reset after the first of three commands
        do_xfer(32'h0, 32'd12288, 1000, -1, 0, 1);
        check_val("t5_error_cleared", error, 1'b0);
        check_val("t5_busy_pre", busy, 1'b1);
        areset = 1'b1;
        #2;
        check_val("t5_busy", busy, 1'b0);
        check_val("t5_cmd_tvalid", cmd_tvalid, 1'b0);
        check_val("t5_cmd_tdata", cmd_tdata, 72'h0);
        check_val("t5_sts_tready", sts_tready, 1'b0);
        check_val("t5_done", done, 1'b0);
        step();
        areset = 1'b0;
        step();
        do_xfer(32'h0, 32'd12288, 0, -1, 0, 0);
        check_val("t5_ncmd", 72'(ncmd), 72'd3);
        check_cmd(0, 32'h0, 23'd4096, 4'd0, 1'b0);

        // zero-length transfer, then a start while busy
        base_addr = 32'h0; total_bytes = 32'd0; start = 1'b1;
        step();
        check_val("t6_done", done, 1'b1);
        check_val("t6_busy", busy, 1'b1);
        check_val("t6_cmd_tvalid", cmd_tvalid, 1'b0);
        total_bytes = 32'd64;
        step();
        start = 1'b0;
        check_val("t6_done_low", done, 1'b0);
        check_val("t6_start_ignored_busy", busy, 1'b0);
        check_val("t6_start_ignored_valid", cmd_tvalid, 1'b0);
        step();
        check_val("t6_still_idle", busy, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/datamover_cmd_gen.md
# datamover_cmd_gen

Issues AXI DataMover S2MM command words that drive the BRAM datamover (`datamover_bram_top`), and consumes the matching status words. A single `start` moves a byte range. The block:
- splits the range into bursts bounded by `MAX_BURST_BYTES`;
- keeps at most `MAX_OUTSTANDING` commands in flight;
- checks returned status tags and error bits;
- pulses `done` when every issued command has been acknowledged.

It sits directly upstream of the DataMover command/status ports, in the `clk_in1` domain.

## Interface
- `ADDR_WIDTH`, 32, byte address width (`SADDR` field).
- `BTT_WIDTH`, 23, bytes-to-transfer field width.
- `MAX_BURST_BYTES`, 4096, max bytes per command. Power of two, ≤ 2^BTT_WIDTH−1.
- `MAX_OUTSTANDING`, 4, max commands issued but not yet status-acknowledged. Range 1..15.
- `clk_in1`  in  1  sole clock.
- `areset`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle request. Sampled only in IDLE.
- `base_addr`  in  32  start byte address. Latched on accepted `start`.
- `total_bytes`  in  32  byte count. Latched on accepted `start`.
- `busy`  out  1  high whenever state ≠ IDLE.
- `done`  out  1  one-cycle pulse at end of transfer.
- `error`  out  1  sticky; cleared on next accepted `start`.
- `cmd_tdata`  out  72  DataMover command word.
- `cmd_tvalid`  out  1  AXI-Stream valid.
- `cmd_tready`  in  1  AXI-Stream ready.
- `sts_tdata`  in  8  DataMover status: [7]=OKAY, [6]=SLVERR, [5]=DECERR, [4]=INTERR, [3:0]=TAG.
- `sts_tvalid`  in  1  status valid.
- `sts_tready`  out  1  status ready.

## Operation
- **Command word layout:** [71:68]=0, [67:64]=TAG, [63:32]=SADDR, [31]=DRR=0, [30]=EOF, [29:24]=DSA=0, [23]=Type=1 (INCR), [22:0]=BTT.
- **FSM states:** IDLE, ISSUE, DRAIN, DONE.
- **IDLE:**
  - `start` with `total_bytes`≠0: latch `addr=base_addr`, `remaining=total_bytes`, `tag=0`, `exp_tag=0`, `outstanding=0`; clear `error`; go to ISSUE.
  - `start` with `total_bytes`=0: clear `error`; go to DONE (no commands).
- **Burst size:** `BTT = min(remaining, MAX_BURST_BYTES − (addr mod MAX_BURST_BYTES))`. No command crosses a `MAX_BURST_BYTES`-aligned boundary.
- **ISSUE:** `cmd_tvalid = (outstanding < MAX_OUTSTANDING)`. EOF=1 only when BTT==remaining.
- **On command handshake:** `addr += BTT`, `remaining −= BTT`, `tag` increments mod 16, `outstanding++`. If new `remaining`==0, go to DRAIN.
- **Status acceptance:** `sts_tready` = 1 in ISSUE and DRAIN, 0 in IDLE and DONE.
- **On status handshake:**
  - `outstanding−−`.
  - Set `error` if OKAY=0, any of [6:4]=1, or TAG≠`exp_tag`.
  - `exp_tag` increments mod 16.
- **Simultaneous command and status handshake:** `outstanding` unchanged.
- **DRAIN:** status handshake with `outstanding`==1 goes to DONE.
- **DONE:** `done`=1 for one cycle, then IDLE.
- **Error handling:** errors never abort. All remaining commands are still issued.
- **`start` while busy:** ignored.
- **Status arriving with `outstanding`==0 in ISSUE:** accepted and flagged as error; counter saturates at 0.
- **Reset:** `areset` mid-transfer returns immediately to IDLE and drops all in-flight state.
- **Reset values:** state=IDLE, `cmd_tvalid`=0, `cmd_tdata`=0, `sts_tready`=0, `busy`=0, `done`=0, `error`=0, all counters 0.

## Timing
- `cmd_tvalid`, `cmd_tdata` and `sts_tready` are decoded only from registers; no combinational path from inputs.
- `start` sampled at edge N: `busy` and first `cmd_tvalid` high from cycle N+1.
- Back-to-back commands: one per cycle while `cmd_tready`=1 and the outstanding limit is not reached.
- `cmd_tdata` holds stable while `cmd_tvalid`=1 and `cmd_tready`=0.
- Final status handshake at edge N: `done` high in cycle N+1, `busy` high in N+1, `busy` low in N+2.
- `total_bytes`=0: `done` in cycle N+1.
- Arithmetic: `remaining` is 32-bit. `addr` wraps modulo 2^32.

## Structure
- Shared package `datamover_pkg`: command field offsets/widths, status bit positions, Type/DSA/DRR constants, FSM state encoding.
- One combinational sub-module `datamover_btt_calc` (inputs `addr`, `remaining`; outputs `BTT`, `eof`). Everything else stays in the top.

## Test plan
- `base_addr`=0x1000, `total_bytes`=10000, `cmd_tready`=1, immediate OKAY status → 3 commands, BTT 4096/4096/1808, SADDR 0x1000/0x2000/0x3000, TAG 0/1/2, EOF only on the third. `done` one cycle after the 3rd status; `error`=0.
- `base_addr`=0xFF0, `total_bytes`=64 → 2 commands, BTT 16 then 48 (boundary split), SADDR 0xFF0 then 0x1000.
- `total_bytes`=40960 with status withheld → exactly 4 commands then `cmd_tvalid`=0. Each status returned releases one more command; 10 commands total.
- Status 0x40|tag (SLVERR) on the 2nd of 3 → `error`=1, all 3 commands still issued, `done` pulses. Next `start` clears `error`.
- `areset` asserted after 1 of 3 commands → all outputs at reset values next cycle. A new `start` begins with TAG 0.
- `start` with `total_bytes`=0 → no `cmd_tvalid`, `done` pulse at N+1. A second `start` while busy → ignored.
